// File: rtl/negedge_capture_bank_if.sv
// Channel bus for negedge_capture_bank: enables, modes, data in/out, flags.
// Parity signals exist only when CAPTURE_PARITY_EN is defined.
interface negedge_capture_bank_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0]       ch_en;
   logic [CHANNELS-1:0]       clr_mode;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic [CHANNELS*WIDTH-1:0] data_out;
   logic [CHANNELS-1:0]       valid;
   logic                      ready;
`ifdef CAPTURE_PARITY_EN
   logic                      parity_odd;
   logic [CHANNELS-1:0]       parity_out;

   modport master (
      output ch_en, clr_mode, data_in, parity_odd,
      input  data_out, valid, ready, parity_out
   );
   modport slave (
      input  ch_en, clr_mode, data_in, parity_odd,
      output data_out, valid, ready, parity_out
   );
`else
   modport master (
      output ch_en, clr_mode, data_in,
      input  data_out, valid, ready
   );
   modport slave (
      input  ch_en, clr_mode, data_in,
      output data_out, valid, ready
   );
`endif
endinterface

// File: rtl/negedge_capture_bank.sv
// Falling-edge multi-channel capture bank with warm-up gating and per-channel clear/hold.
// Optional per-channel parity output is enabled by defining CAPTURE_PARITY_EN.
module negedge_capture_bank #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int WARMUP   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   negedge_capture_bank_if.slave   bus
);

   localparam logic [7:0] WARM = 8'(WARMUP);

   logic [7:0]                cnt_p0;
   logic [7:0]                cnt_nxt;
   logic                      ready_p0;
   logic [CHANNELS*WIDTH-1:0] data_p0;
   logic [CHANNELS*WIDTH-1:0] data_nxt;
   logic [CHANNELS-1:0]       vld_p0;
   logic [CHANNELS-1:0]       vld_nxt;
`ifdef CAPTURE_PARITY_EN
   logic [CHANNELS-1:0]       par_p0;
   logic [CHANNELS-1:0]       par_nxt;

   // Inversion only applies to words that are being marked valid.
   function automatic logic parity_calc(input logic [WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction
`endif

   always_comb begin
      cnt_nxt = cnt_p0;
      if (cnt_p0 != WARM) cnt_nxt = cnt_p0 + 8'd1;
   end

   // Channel decisions use the ready registered before this edge.
   always_comb begin
      data_nxt = data_p0;
      vld_nxt  = vld_p0;
`ifdef CAPTURE_PARITY_EN
      par_nxt  = par_p0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
         if (!ready_p0 || (!bus.ch_en[i] && bus.clr_mode[i])) begin
            data_nxt[i*WIDTH +: WIDTH] = '0;
            vld_nxt[i]                 = 1'b0;
`ifdef CAPTURE_PARITY_EN
            par_nxt[i]                 = 1'b0;
`endif
         end else if (bus.ch_en[i]) begin
            data_nxt[i*WIDTH +: WIDTH] = bus.data_in[i*WIDTH +: WIDTH];
            vld_nxt[i]                 = 1'b1;
`ifdef CAPTURE_PARITY_EN
            par_nxt[i] = parity_calc(bus.data_in[i*WIDTH +: WIDTH], bus.parity_odd);
`endif
         end
      end
   end

   // p0: single falling-edge register stage for counter, flags and data
   always_ff @(negedge clk) begin
      if (rst) begin
         cnt_p0   <= '0;
         ready_p0 <= 1'b0;
         data_p0  <= '0;
         vld_p0   <= '0;
`ifdef CAPTURE_PARITY_EN
         par_p0   <= '0;
`endif
      end else begin
         cnt_p0   <= cnt_nxt;
         ready_p0 <= (cnt_nxt == WARM);
         data_p0  <= data_nxt;
         vld_p0   <= vld_nxt;
`ifdef CAPTURE_PARITY_EN
         par_p0   <= par_nxt;
`endif
      end
   end

   assign bus.ready    = ready_p0;
   assign bus.data_out = data_p0;
   assign bus.valid    = vld_p0;
`ifdef CAPTURE_PARITY_EN
   assign bus.parity_out = par_p0;
`endif

endmodule

// File: tb/tb_negedge_capture_bank.sv
// Bench for negedge_capture_bank: WARMUP=3 and WARMUP=0 instances, directed steps then random.
module tb_negedge_capture_bank;
   localparam int W  = 32;
   localparam int CH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [CH-1:0]  ch_en;
   logic [CH-1:0]  clr_mode;
   logic [CH*W-1:0] data_in;
`ifdef CAPTURE_PARITY_EN
   logic           parity_odd;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   negedge_capture_bank_if #(.WIDTH(W), .CHANNELS(CH)) if0 ();
   negedge_capture_bank_if #(.WIDTH(W), .CHANNELS(CH)) if1 ();

   assign if0.ch_en = ch_en;  assign if0.clr_mode = clr_mode;  assign if0.data_in = data_in;
   assign if1.ch_en = ch_en;  assign if1.clr_mode = clr_mode;  assign if1.data_in = data_in;
`ifdef CAPTURE_PARITY_EN
   assign if0.parity_odd = parity_odd;
   assign if1.parity_odd = parity_odd;
`endif

   negedge_capture_bank #(.WIDTH(W), .CHANNELS(CH), .WARMUP(3)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   negedge_capture_bank #(.WIDTH(W), .CHANNELS(CH), .WARMUP(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   // Reference model: edges seen since reset release, plus per-channel word/flag/parity.
   int          m_edges [2];
   bit          m_rdy   [2];
   logic [W-1:0] m_data [2][CH];
   bit          m_vld   [2][CH];
   bit          m_par   [2][CH];
   int          warm    [2] = '{3, 0};

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit was_ready;
         was_ready = m_rdy[k];
         if (rst) begin
            m_edges[k] = 0;
            m_rdy[k]   = 0;
            for (int c = 0; c < CH; c++) begin
               m_data[k][c] = '0; m_vld[k][c] = 0; m_par[k][c] = 0;
            end
         end else begin
            if (m_edges[k] < warm[k]) m_edges[k]++;
            m_rdy[k] = (m_edges[k] == warm[k]);
            for (int c = 0; c < CH; c++) begin
               if (!was_ready || (!ch_en[c] && clr_mode[c])) begin
                  m_data[k][c] = '0; m_vld[k][c] = 0; m_par[k][c] = 0;
               end else if (ch_en[c]) begin
                  m_data[k][c] = data_in[c*W +: W];
                  m_vld[k][c]  = 1;
`ifdef CAPTURE_PARITY_EN
                  m_par[k][c]  = (^data_in[c*W +: W]) ^ parity_odd;
`endif
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [CH*W-1:0] ed;
      logic [CH-1:0]   ev, ep;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < CH; c++) begin
            ed[c*W +: W] = m_data[k][c];
            ev[c] = m_vld[k][c];
            ep[c] = m_par[k][c];
         end
         if (k == 0) begin
            chk("w3_ready", {127'b0, if0.ready}, {127'b0, m_rdy[0]});
            chk("w3_valid", {124'b0, if0.valid}, {124'b0, ev});
            chk("w3_data",  if0.data_out, ed);
`ifdef CAPTURE_PARITY_EN
            chk("w3_parity", {124'b0, if0.parity_out}, {124'b0, ep});
`endif
         end else begin
            chk("w0_ready", {127'b0, if1.ready}, {127'b0, m_rdy[1]});
            chk("w0_valid", {124'b0, if1.valid}, {124'b0, ev});
            chk("w0_data",  if1.data_out, ed);
`ifdef CAPTURE_PARITY_EN
            chk("w0_parity", {124'b0, if1.parity_out}, {124'b0, ep});
`endif
         end
      end
   endtask

   // One falling edge: inputs were set beforehand, outputs checked at the next rising edge.
   task automatic step();
      @(negedge clk);
      model_edge();
      @(posedge clk);
      compare_all();
   endtask

   initial begin
      rst = 1'b1; ch_en = '1; clr_mode = '0; data_in = {4{32'hA5A5_A5A5}};
`ifdef CAPTURE_PARITY_EN
      parity_odd = 1'b0;
`endif
      for (int k = 0; k < 2; k++) m_rdy[k] = 0;
      step(); step();
      chk("rst_data", if0.data_out, '0);

      rst = 1'b0;
      step();
      chk("e1_w3_ready", {127'b0, if0.ready}, '0);
      chk("e1_w0_ready", {127'b0, if1.ready}, 128'd1);
      step();
      chk("e2_w3_valid", {124'b0, if0.valid}, '0);
      chk("e2_w0_data",  if1.data_out, {4{32'hA5A5_A5A5}});
      step();
      chk("e3_w3_ready", {127'b0, if0.ready}, 128'd1);
      chk("e3_w3_valid", {124'b0, if0.valid}, '0);
      step();
      chk("e4_w3_data",  if0.data_out, {4{32'hA5A5_A5A5}});
      chk("e4_w3_valid", {124'b0, if0.valid}, 128'hF);

      ch_en = '0; clr_mode = '1; step();
      ch_en = 4'b0101; data_in = {32'h4, 32'h3, 32'h2, 32'h1}; step();
      chk("perch_data",  if0.data_out, {32'h0, 32'h3, 32'h0, 32'h1});
      chk("perch_valid", {124'b0, if0.valid}, 128'h5);

      ch_en = '1; data_in = {4{32'hFF}}; step();
      ch_en = '0; clr_mode = 4'b0011; data_in = {$urandom, $urandom, $urandom, $urandom}; step();
      chk("hold_data",  if0.data_out, {32'hFF, 32'hFF, 32'h0, 32'h0});
      chk("hold_valid", {124'b0, if0.valid}, 128'hC);
      data_in = {$urandom, $urandom, $urandom, $urandom}; step();
      clr_mode = 4'b1111; step();
      chk("hold_to_clr", if0.data_out, '0);

      ch_en = '1; data_in = {4{32'h1234}}; step();
      rst = 1'b1; step();
      chk("mid_rst_data",  if0.data_out, '0);
      chk("mid_rst_ready", {127'b0, if0.ready}, '0);
      rst = 1'b0;
      for (int e = 0; e < 3; e++) begin
         step();
         chk("rewarm_valid", {124'b0, if0.valid}, '0);
      end
      step();
      chk("rewarm_cap", if0.data_out, {4{32'h1234}});

`ifdef CAPTURE_PARITY_EN
      data_in = {4{32'h7}}; parity_odd = 1'b0; step();
      chk("par_even", {124'b0, if0.parity_out}, 128'hF);
      parity_odd = 1'b1; step();
      chk("par_odd", {124'b0, if0.parity_out}, '0);
      parity_odd = 1'b0; step();
      ch_en = '0; clr_mode = '1; step();
      chk("par_clr", {124'b0, if0.parity_out}, '0);
`endif

      for (int n = 0; n < 300; n++) begin
         rst      = ($urandom_range(0, 39) == 0);
         ch_en    = 4'($urandom);
         clr_mode = 4'($urandom);
         data_in  = {$urandom, $urandom, $urandom, $urandom};
`ifdef CAPTURE_PARITY_EN
         parity_odd = 1'($urandom);
`endif
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/negedge_capture_bank.md
Name: negedge_capture_bank

Overview:
Multi-channel, falling-edge register bank. It replaces the single enable-flop-plus-level-latch arrangement with fully edge-triggered capture. A warm-up counter gates capture for a fixed number of falling edges after reset. Each channel has its own enable and a selectable disable behaviour (clear or hold) and reports a per-channel valid flag. It sits between upstream data sources and downstream logic that samples on the rising edge, giving half a cycle of setup margin.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of independent channels (≥1).
- WARMUP, 3, falling edges after reset release before capture is allowed (0..255).

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  reset.
- ch_en  input  CHANNELS  per-channel capture enable.
- clr_mode  input  CHANNELS  per-channel disable mode: 1 = clear when disabled, 0 = hold when disabled.
- data_in  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- data_out  output  CHANNELS*WIDTH  registered captured data, same packing as data_in.
- valid  output  CHANNELS  per-channel flag: data_out[i] holds captured data.
- ready  output  1  warm-up complete; capture permitted.

Behaviour:
- Reset:
  - Reset rst, synchronous, active-high. It is sampled on the falling edge of clk.
  - While rst is high at a falling edge: warm-up count = 0, ready = 0, data_out = 0, valid = 0 for all channels.
  - Every output is 0 after reset.
- No latches anywhere. Every storage element is a falling-edge flop. There are no combinational paths from inputs to outputs.
- Warm-up counter:
  - 8-bit count. At each falling edge with rst low: if count != WARMUP, count increments; otherwise it saturates.
  - ready is registered and equals (next count == WARMUP).
  - WARMUP=0: ready = 1 on the first falling edge with rst low.
  - WARMUP=3: ready = 1 on the third falling edge after rst is released.
- Per-channel update at each falling edge with rst low. Evaluated in priority order, using the ready value registered before this edge:
  1. ready = 0: data_out[i] = 0, valid[i] = 0.
  2. ch_en[i] = 1: data_out[i] = data_in[i], valid[i] = 1.
  3. ch_en[i] = 0 and clr_mode[i] = 1: data_out[i] = 0, valid[i] = 0.
  4. ch_en[i] = 0 and clr_mode[i] = 0: data_out[i] and valid[i] hold.
- Latency: data_in is sampled at falling edge N and visible on data_out immediately after edge N. Output is stable from edge N to edge N+1, so downstream rising-edge logic samples it half a cycle later.
- Channels are fully independent. Any mix of enables and modes in the same edge is legal.
- clr_mode change while disabled:
  - Holding channel switched to clear: it clears at the next falling edge.
  - Clear channel switched to hold: it keeps 0 with valid = 0.
- Reset mid-operation overrides everything at that edge. After reset, the full WARMUP sequence repeats before any capture.
- rst and ch_en high at the same edge: reset wins.

Optional Feature:
- Macro: CAPTURE_PARITY_EN.
- When defined:
  - Adds output parity_out (CHANNELS bits).
  - parity_out[i] is registered in the same edge and same branch as data_out[i]: the XOR of the WIDTH bits written to data_out[i]. It is 0 when cleared or reset and held when data_out holds.
  - Adds input parity_odd (1 bit). When 1, the channel's parity is inverted, but only for channels with valid[i] = 1.
- When undefined: neither port exists and there is no parity logic. All other behaviour is identical.

Test Plan:
- Reset/warm-up, WARMUP=3: hold rst 2 edges, release, ch_en=all 1, data_in=0xA5A5A5A5 on all channels → ready=0 and valid=0 for edges 1-2, ready=1 after edge 3, data_out=0xA5A5A5A5 and valid=1 after edge 4.
- Per-channel capture, after ready: ch_en=4'b0101, data_in ch0..3 = 0x1,0x2,0x3,0x4, prior outputs 0 → data_out ch0=0x1, ch2=0x3, ch1/ch3=0, valid=4'b0101.
- Clear vs hold: all channels captured 0xFF, then ch_en=0 with clr_mode=4'b0011 → ch0/ch1 = 0, valid 0; ch2/ch3 stay 0xFF, valid 1. Data_in changes while disabled are ignored.
- Reset mid-operation: all channels valid with 0x1234, assert rst for 1 edge with ch_en=all 1 → all outputs 0 and ready=0; capture resumes only WARMUP+1 edges after release.
- WARMUP=0 edge case: release rst with ch_en=1, data_in=0x7 → ready=1 after edge 1, data_out=0x7 after edge 2.
- CAPTURE_PARITY_EN: capture 0x00000007 with parity_odd=0 → parity_out[i]=1; parity_odd=1 → 0. Disable with clr_mode=1 → parity_out=0.
